// File: rtl/mc_cpu_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS datapath and its sequencer.
interface mc_cpu_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   // datapath -> controller
   logic             run_en;
   logic [5:0]       opcode;
   logic             alu_zero;
   logic             alu_overflow;
   logic             mem_ready;
   // controller -> datapath
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             ir_write;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             epc_write;
   logic [1:0]       cause;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;

   // controller side
   modport slave (
      input  run_en, opcode, alu_zero, alu_overflow, mem_ready,
      output pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, epc_write,
             cause, state, instr_count
   );

   // datapath side
   modport master (
      output run_en, opcode, alu_zero, alu_overflow, mem_ready,
      input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, epc_write,
             cause, state, instr_count
   );
endinterface

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// precise exceptions through EPC and a retired-instruction counter.
module mc_cpu_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic          SYS_clk,
   input  logic          SYS_reset,
   mc_cpu_ctrl_if.slave  bus
);
   localparam int unsigned TMO_W = 8;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_R     = 4'd7,
      S_WB_I     = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_EXCEPT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   state_t           r_state;
   logic [1:0]       r_cause;
   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_ovf;

   state_t     w_next;
   logic       w_cause_en;
   logic [1:0] w_cause_set;
   logic       w_retire;
   logic       w_wait;
   logic       w_tmo_hit;
   logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
   logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_epc_write;
   logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;

   // the wait that would be the MEM_TIMEOUT-th consecutive one ends the access
   assign w_tmo_hit = (r_tmo == TMO_W'(MEM_TIMEOUT - 1));

   // next-state decode and control outputs (some terms depend on live inputs)
   always_comb begin
      w_next       = r_state;
      w_cause_en   = 1'b0;
      w_cause_set  = 2'b00;
      w_retire     = 1'b0;
      w_wait       = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'b00;
      w_ir_write   = 1'b0;
      w_iord       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_dst    = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      w_epc_write  = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (bus.run_en) begin
               w_mem_read  = 1'b1;
               w_alu_src_b = 2'b01;
               if (bus.mem_ready) begin
                  w_ir_write = 1'b1;
                  w_pc_write = 1'b1;
                  w_next     = S_DECODE;
               end else begin
                  w_wait = 1'b1;
                  if (w_tmo_hit) begin
                     w_next      = S_EXCEPT;
                     w_cause_en  = 1'b1;
                     w_cause_set = 2'b11;
                  end
               end
            end
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            case (bus.opcode)
               OP_RTYPE:       w_next = S_EXEC_R;
               OP_ADDI:        w_next = S_EXEC_I;
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J:           w_next = S_JUMP;
               default: begin
                  w_next      = S_EXCEPT;
                  w_cause_en  = 1'b1;
                  w_cause_set = 2'b01;
               end
            endcase
         end
         S_EXEC_R: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
            w_next      = S_WB_R;
         end
         S_EXEC_I: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_next      = S_WB_I;
         end
         S_WB_R, S_WB_I: begin
            if (r_ovf) begin
               w_next      = S_EXCEPT;
               w_cause_en  = 1'b1;
               w_cause_set = 2'b10;
            end else begin
               w_reg_write = 1'b1;
               w_reg_dst   = (r_state == S_WB_R);
               w_next      = S_FETCH;
               w_retire    = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_next      = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD, S_MEM_WR: begin
            w_iord      = 1'b1;
            w_mem_read  = (r_state == S_MEM_RD);
            w_mem_write = (r_state == S_MEM_WR);
            if (bus.mem_ready) begin
               if (r_state == S_MEM_RD) begin
                  w_next = S_WB_MEM;
               end else begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
            end else begin
               w_wait = 1'b1;
               if (w_tmo_hit) begin
                  w_next      = S_EXCEPT;
                  w_cause_en  = 1'b1;
                  w_cause_set = 2'b11;
               end
            end
         end
         S_WB_MEM: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_next       = S_FETCH;
            w_retire     = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b01;
            w_pc_src    = 2'b01;
            w_pc_write  = ((bus.opcode == OP_BEQ) &&  bus.alu_zero) ||
                          ((bus.opcode == OP_BNE) && !bus.alu_zero);
            w_next      = S_FETCH;
            w_retire    = 1'b1;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
            w_next     = S_FETCH;
            w_retire   = 1'b1;
         end
         S_EXCEPT: begin
            w_epc_write = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_src    = 2'b11;
            w_next      = S_FETCH;
         end
         default: begin
            w_next      = S_EXCEPT;
            w_cause_en  = 1'b1;
            w_cause_set = 2'b01;
         end
      endcase
      // reset overrides every control strobe in the same cycle
      if (SYS_reset) begin
         w_pc_write   = 1'b0;
         w_pc_src     = 2'b00;
         w_ir_write   = 1'b0;
         w_iord       = 1'b0;
         w_mem_read   = 1'b0;
         w_mem_write  = 1'b0;
         w_mem_to_reg = 1'b0;
         w_reg_dst    = 1'b0;
         w_reg_write  = 1'b0;
         w_alu_src_a  = 1'b0;
         w_alu_src_b  = 2'b00;
         w_alu_op     = 2'b00;
         w_epc_write  = 1'b0;
      end
   end

   // state, cause, retire counter, memory-wait counter and overflow capture
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         r_state <= S_FETCH;
         r_cause <= 2'b00;
         r_cnt   <= '0;
         r_tmo   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_cause_en) r_cause <= w_cause_set;
         if (w_retire)   r_cnt   <= r_cnt + CNT_W'(1);
         if (w_wait && (w_next == r_state)) r_tmo <= r_tmo + TMO_W'(1);
         else                               r_tmo <= '0;
         if ((r_state == S_EXEC_R) || (r_state == S_EXEC_I)) r_ovf <= bus.alu_overflow;
      end
   end

   assign bus.pc_write    = w_pc_write;
   assign bus.pc_src      = w_pc_src;
   assign bus.ir_write    = w_ir_write;
   assign bus.iord        = w_iord;
   assign bus.mem_read    = w_mem_read;
   assign bus.mem_write   = w_mem_write;
   assign bus.mem_to_reg  = w_mem_to_reg;
   assign bus.reg_dst     = w_reg_dst;
   assign bus.reg_write   = w_reg_write;
   assign bus.alu_src_a   = w_alu_src_a;
   assign bus.alu_src_b   = w_alu_src_b;
   assign bus.alu_op      = w_alu_op;
   assign bus.epc_write   = w_epc_write;
   assign bus.cause       = r_cause;
   assign bus.state       = r_state;
   assign bus.instr_count = r_cnt;
endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Directed bench for the multi-cycle sequencer: state traces, exceptions,
// memory wait/timeout, branch conditions, reset and halt.
module tb_mc_cpu_ctrl;
   logic SYS_clk;
   logic SYS_reset;
   int   total;
   int   bad;

   mc_cpu_ctrl_if #(.CNT_W(16)) bus ();

   mc_cpu_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .SYS_clk   (SYS_clk),
      .SYS_reset (SYS_reset),
      .bus       (bus)
   );

   // packed control view: pc_write,pc_src,ir_write,iord,mem_read,mem_write,
   // mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,epc_write
   logic [15:0] w_ctl;
   assign w_ctl = {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
                   bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                   bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.epc_write};

   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SYS_clk);
      #2;
   endtask

   // run n cycles checking the state trace (nibble 0 first) and the control
   // vector in the first and last cycle
   task automatic trace(input string tag, input logic [5:0] op, input int n,
                        input logic [23:0] seq, input logic [15:0] ctl_first,
                        input logic [15:0] ctl_last);
      bus.opcode = op;
      #1;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.st%0d", tag, i), 32'(bus.state), 32'(seq[4*i +: 4]));
         if (i == 0)     chk($sformatf("%s.ctl0", tag), 32'(w_ctl), 32'(ctl_first));
         if (i == n - 1) chk($sformatf("%s.ctlN", tag), 32'(w_ctl), 32'(ctl_last));
         tick();
      end
   endtask

   localparam logic [15:0] C_FETCH = 16'h9408;

   initial begin
      total = 0;
      bad   = 0;
      SYS_reset        = 1'b1;
      bus.run_en       = 1'b1;
      bus.opcode       = 6'h00;
      bus.alu_zero     = 1'b1;
      bus.alu_overflow = 1'b0;
      bus.mem_ready    = 1'b1;
      tick();
      tick();
      chk("rst.state", 32'(bus.state), 32'd0);
      chk("rst.cause", 32'(bus.cause), 32'd0);
      chk("rst.cnt", 32'(bus.instr_count), 32'd0);
      chk("rst.ctl", 32'(w_ctl), 32'h0);
      SYS_reset = 1'b0;

      // main instruction mix, mem_ready tied high
      trace("r",   6'h00, 4, 24'h007210, C_FETCH, 16'h00C0);
      trace("lw",  6'h23, 5, 24'h095410, C_FETCH, 16'h0140);
      trace("sw",  6'h2B, 4, 24'h006410, C_FETCH, 16'h0A00);
      trace("beq", 6'h04, 3, 24'h000A10, C_FETCH, 16'hA022);
      trace("j",   6'h02, 3, 24'h000B10, C_FETCH, 16'hC000);
      chk("mix.state", 32'(bus.state), 32'd0);
      chk("mix.cnt", 32'(bus.instr_count), 32'd5);

      // illegal opcode
      trace("ill", 6'h3F, 3, 24'h000C10, C_FETCH, 16'hE001);
      chk("ill.cause", 32'(bus.cause), 32'd1);
      chk("ill.cnt", 32'(bus.instr_count), 32'd5);
      chk("ill.state", 32'(bus.state), 32'd0);

      // overflow: WB_R writes nothing, then EXCEPT
      bus.alu_overflow = 1'b1;
      trace("ovf", 6'h00, 4, 24'h007210, C_FETCH, 16'h0000);
      chk("ovf.exc_state", 32'(bus.state), 32'd12);
      chk("ovf.exc_ctl", 32'(w_ctl), 32'hE001);
      bus.alu_overflow = 1'b0;
      tick();
      chk("ovf.cause", 32'(bus.cause), 32'd2);
      chk("ovf.cnt", 32'(bus.instr_count), 32'd5);

      // load with 3 wait cycles
      trace("lwp", 6'h23, 3, 24'h000410, C_FETCH, 16'h0030);
      bus.mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wait.st%0d", i), 32'(bus.state), 32'd5);
         chk($sformatf("wait.ctl%0d", i), 32'(w_ctl), 32'h0C00);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("wait.rdy_st", 32'(bus.state), 32'd5);
      chk("wait.rdy_ctl", 32'(w_ctl), 32'h0C00);
      tick();
      chk("wait.wbmem", 32'(bus.state), 32'd9);
      tick();
      chk("wait.cnt", 32'(bus.instr_count), 32'd6);

      // load that never completes: 15 waiting cycles then EXCEPT
      trace("tmop", 6'h23, 3, 24'h000410, C_FETCH, 16'h0030);
      bus.mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("tmo.st%0d", i), 32'(bus.state), 32'd5);
         tick();
      end
      chk("tmo.exc", 32'(bus.state), 32'd12);
      bus.mem_ready = 1'b1;
      tick();
      chk("tmo.cause", 32'(bus.cause), 32'd3);
      chk("tmo.cnt", 32'(bus.instr_count), 32'd6);

      // bne: not taken with zero, taken without
      bus.alu_zero = 1'b1;
      trace("bne0", 6'h05, 3, 24'h000A10, C_FETCH, 16'h2022);
      bus.alu_zero = 1'b0;
      trace("bne1", 6'h05, 3, 24'h000A10, C_FETCH, 16'hA022);
      chk("bne.cnt", 32'(bus.instr_count), 32'd8);

      // reset in the middle of a store wait
      trace("swp", 6'h2B, 3, 24'h000410, C_FETCH, 16'h0030);
      bus.mem_ready = 1'b0;
      #1;
      chk("swr.st", 32'(bus.state), 32'd6);
      chk("swr.ctl", 32'(w_ctl), 32'h0A00);
      tick();
      SYS_reset = 1'b1;
      #1;
      chk("swr.rst_ctl", 32'(w_ctl), 32'h0);
      tick();
      chk("swr.state", 32'(bus.state), 32'd0);
      chk("swr.cnt", 32'(bus.instr_count), 32'd0);
      chk("swr.cause", 32'(bus.cause), 32'd0);
      chk("swr.ctl2", 32'(w_ctl), 32'h0);

      // halted: FETCH held, no request
      SYS_reset     = 1'b0;
      bus.run_en    = 1'b0;
      bus.mem_ready = 1'b1;
      bus.opcode    = 6'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("halt.st%0d", i), 32'(bus.state), 32'd0);
         chk($sformatf("halt.ctl%0d", i), 32'(w_ctl), 32'h0);
      end
      bus.run_en = 1'b1;
      #1;
      chk("halt.resume", 32'(w_ctl), 32'(C_FETCH));
      tick();
      chk("halt.decode", 32'(bus.state), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
